// File: rtl/credit_reg_bank.sv
// Bank of per-channel credit registers with LOAD / saturating ADD / guarded SUB / CLEAR; 1-cycle op latency.
// No backpressure: every en strobe is accepted; q/zero are a combinational view of channel sel.
module credit_reg_bank #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             ovf,
  output logic             unf,
  output logic             done
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_ch [CHANNELS];
  logic             r_ovf;
  logic             r_unf;
  logic             r_done;

  logic             w_sel_ok;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_nxt;
  logic             w_set_ovf;
  logic             w_set_unf;

  // Out-of-range sel (non-power-of-two bank) matches no channel, so it reads 0.
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SELW'(i) == sel) w_cur = r_ch[i];
    end
  end

  assign w_sel_ok = (32'(sel) < 32'(CHANNELS));
  assign w_sum    = {1'b0, w_cur} + {1'b0, d};

  always_comb begin
    w_nxt     = w_cur;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case (op_e'(op))
      OP_LOAD: begin
        if ({1'b0, d} > MAX_EXT) begin
          w_nxt     = MAX_W;
          w_set_ovf = 1'b1;
        end else begin
          w_nxt = d;
        end
      end
      OP_ADD: begin
        if (w_sum > MAX_EXT) begin
          w_nxt     = MAX_W;
          w_set_ovf = 1'b1;
        end else begin
          w_nxt = w_sum[WIDTH-1:0];
        end
      end
      OP_SUB: begin
        // A refused SUB leaves the credit untouched rather than wrapping.
        if (d <= w_cur) w_nxt = w_cur - d;
        else            w_set_unf = 1'b1;
      end
      default: w_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) r_ch[i] <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_done <= 1'b0;
    end else if (clr_all) begin
      for (int i = 0; i < CHANNELS; i++) r_ch[i] <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_done <= 1'b1;
    end else begin
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_done <= 1'b0;
      if (en && w_sel_ok) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (SELW'(i) == sel) r_ch[i] <= w_nxt;
        end
        r_ovf  <= w_set_ovf;
        r_unf  <= w_set_unf;
        r_done <= 1'b1;
      end
    end
  end

  assign q    = w_cur;
  assign zero = (w_cur == '0);
  assign ovf  = r_ovf;
  assign unf  = r_unf;
  assign done = r_done;

endmodule

// File: tb/tb_credit_reg_bank.sv
// Directed bench for credit_reg_bank: an integer-arithmetic model checked every cycle plus literal expectations.
module tb_credit_reg_bank;

  localparam int W    = 5;
  localparam int CH   = 4;
  localparam int MAXV = 31;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr_all = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [1:0]   sel = 2'b00;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         zero, ovf, unf, done;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ch [CH] = '{default: 0};
  int m_cur;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit m_done = 1'b0;

  credit_reg_bank #(.WIDTH(W), .CHANNELS(CH), .MAX_VAL(MAXV)) dut (
    .clk(clk), .rst(rst), .clr_all(clr_all), .en(en), .op(op), .sel(sel), .d(d),
    .q(q), .zero(zero), .ovf(ovf), .unf(unf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the credit rules, using plain integers.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < CH; i++) m_ch[i] = 0;
      m_ovf = 0; m_unf = 0; m_done = 0;
    end else if (clr_all) begin
      for (int i = 0; i < CH; i++) m_ch[i] = 0;
      m_ovf = 0; m_unf = 0; m_done = 1;
    end else begin
      m_ovf = 0; m_unf = 0; m_done = 0;
      if (en && int'(sel) < CH) begin
        m_cur  = m_ch[sel];
        m_done = 1;
        case (op)
          2'b00: begin m_ovf = (int'(d) > MAXV); m_ch[sel] = m_ovf ? MAXV : int'(d); end
          2'b01: begin m_ovf = (m_cur + int'(d) > MAXV); m_ch[sel] = m_ovf ? MAXV : m_cur + int'(d); end
          2'b10: begin
            if (int'(d) <= m_cur) m_ch[sel] = m_cur - int'(d);
            else m_unf = 1;
          end
          default: m_ch[sel] = 0;
        endcase
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  always @(negedge clk) begin
    chk("cyc_q",    32'(q),    (int'(sel) < CH) ? m_ch[sel] : 0);
    chk("cyc_zero", 32'(zero), ((int'(sel) < CH ? m_ch[sel] : 0) == 0) ? 1 : 0);
    chk("cyc_ovf",  32'(ovf),  32'(m_ovf));
    chk("cyc_unf",  32'(unf),  32'(m_unf));
    chk("cyc_done", 32'(done), 32'(m_done));
  end

  task automatic op_cyc(input logic [1:0] o, input logic [1:0] s, input logic [W-1:0] dd);
    en = 1'b1; op = o; sel = s; d = dd;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with a pending LOAD 15 that must be ignored.
    en = 1'b1; op = 2'b00; sel = 2'd0; d = 5'd15;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < CH; s++) begin
      sel = 2'(s); #1;
      chk("rst_q", 32'(q), 0);
      chk("rst_zero", 32'(zero), 1);
      chk("rst_flags", {29'd0, ovf, unf, done}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;

    op_cyc(2'b00, 2'd0, 5'd15);
    chk("ld15_q", 32'(q), 15);
    chk("ld15_done", 32'(done), 1);
    chk("ld15_zero", 32'(zero), 0);
    chk("model_ch0_15", 32'(m_ch[0]), 15);
    idle();
    chk("ld15_done_pulse", 32'(done), 0);

    // Saturating ADD around the ceiling.
    op_cyc(2'b00, 2'd1, 5'd20);
    op_cyc(2'b01, 2'd1, 5'd11);
    chk("add_exact_q", 32'(q), 31);
    chk("add_exact_ovf", 32'(ovf), 0);
    op_cyc(2'b01, 2'd1, 5'd1);
    chk("add_sat_q", 32'(q), 31);
    chk("add_sat_ovf", 32'(ovf), 1);
    op_cyc(2'b00, 2'd1, 5'd31);
    chk("ld31_ovf", 32'(ovf), 0);
    chk("ld31_q", 32'(q), 31);

    // Guarded SUB.
    op_cyc(2'b00, 2'd2, 5'd10);
    op_cyc(2'b10, 2'd2, 5'd10);
    chk("sub_eq_q", 32'(q), 0);
    chk("sub_eq_zero", 32'(zero), 1);
    chk("sub_eq_unf", 32'(unf), 0);
    op_cyc(2'b10, 2'd2, 5'd1);
    chk("sub_ref_q", 32'(q), 0);
    chk("sub_ref_unf", 32'(unf), 1);
    chk("sub_ref_done", 32'(done), 1);
    chk("model_unf", 32'(m_unf), 1);
    idle();
    chk("sub_unf_pulse", 32'(unf), 0);

    // Channel isolation.
    op_cyc(2'b00, 2'd0, 5'd5);
    op_cyc(2'b00, 2'd3, 5'd9);
    op_cyc(2'b11, 2'd3, 5'd0);
    sel = 2'd0; #1;
    chk("iso_ch0", 32'(q), 5);
    sel = 2'd3; #1;
    chk("iso_ch3", 32'(q), 0);
    idle();

    // clr_all beats a simultaneous ADD.
    op_cyc(2'b00, 2'd2, 5'd7);
    op_cyc(2'b00, 2'd3, 5'd4);
    clr_all = 1'b1; en = 1'b1; op = 2'b01; sel = 2'd1; d = 5'd3;
    @(posedge clk); #1;
    clr_all = 1'b0; en = 1'b0;
    chk("clr_done", 32'(done), 1);
    chk("clr_ovf", 32'(ovf), 0);
    for (int s = 0; s < CH; s++) begin
      sel = 2'(s); #1;
      chk("clr_q", 32'(q), 0);
    end
    idle();

    // Async reset in the middle of an ADD burst.
    op_cyc(2'b01, 2'd1, 5'd5);
    en = 1'b1; op = 2'b01; sel = 2'd1; d = 5'd2;
    @(posedge clk); #1;
    chk("burst_q", 32'(q), 7);
    #1 rst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 0);
    chk("arst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    op_cyc(2'b01, 2'd1, 5'd3);
    chk("post_rst_q", 32'(q), 3);
    chk("model_ch1_3", 32'(m_ch[1]), 3);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
